// File: rtl/mlp_pkg.sv
// Shared types and default sizing for the MLP input stage: bank states,
// filler FSM states and the default frame geometry.
package mlp_pkg;
  localparam int N_DEFAULT                = 8;
  localparam int NUM_INPUTS_DEFAULT       = 62;
  localparam int CLOG2_NUM_INPUTS_DEFAULT = 6;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

  typedef enum logic {
    FSM_FILL  = 1'b0,
    FSM_DRAIN = 1'b1
  } fill_state_t;
endpackage

// File: rtl/mlp_frame_bank.sv
// One frame bank: pixel register array written one pixel at a time, a state
// register, and the whole frame exposed as a flat vector.
module mlp_frame_bank
  import mlp_pkg::*;
#(
  parameter int n                      = N_DEFAULT,
  parameter int number_of_inputs       = NUM_INPUTS_DEFAULT,
  parameter int clog2_number_of_inputs = CLOG2_NUM_INPUTS_DEFAULT
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_wr_en,
  input  logic [clog2_number_of_inputs-1:0] i_idx,
  input  logic [n-1:0]                      i_pixel,
  input  bank_state_t                       i_state_d,
  output bank_state_t                       o_state,
  output logic [number_of_inputs*n-1:0]     o_data
);
  logic [n-1:0] r_pix [number_of_inputs];
  bank_state_t  r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= BANK_EMPTY;
    else     r_state <= i_state_d;
  end

  // Pixel storage carries no reset; the top gates it off whenever the bank is not FULL.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_pix[i_idx] <= i_pixel;
  end

  for (genvar g = 0; g < number_of_inputs; g++) begin : g_flat
    assign o_data[g*n +: n] = r_pix[g];
  end

  assign o_state = r_state;
endmodule

// File: rtl/mlp_input_buffer.sv
// Ping-pong input buffer: assembles a serial pixel stream into full frames,
// holding one frame for the MLP while the other bank fills.
module mlp_input_buffer
  import mlp_pkg::*;
#(
  parameter int n                      = N_DEFAULT,
  parameter int number_of_inputs       = NUM_INPUTS_DEFAULT,
  parameter int clog2_number_of_inputs = CLOG2_NUM_INPUTS_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [n-1:0]                  in_data,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [number_of_inputs*n-1:0] data,
  input  logic                          frame_release,
  output logic                          frame_error
);
  localparam int DW = number_of_inputs * n;
  localparam logic [clog2_number_of_inputs-1:0] LAST_IDX =
    clog2_number_of_inputs'(number_of_inputs - 1);

  logic                              r_run;
  logic                              r_wr_ptr;
  logic                              r_rd_ptr;
  logic [clog2_number_of_inputs-1:0] r_idx;
  fill_state_t                       r_fill_st;
  logic                              r_frame_error;

  bank_state_t w_state   [2];
  bank_state_t w_state_d [2];
  logic [DW-1:0] w_bank_data [2];
  logic [1:0]  w_wr_sel;
  logic [1:0]  w_rd_sel;
  bank_state_t w_wr_state;
  bank_state_t w_rd_state;
  logic [DW-1:0] w_rd_data;
  logic w_accept, w_fill_beat, w_at_last, w_complete, w_bad_frame, w_missing, w_release;

  assign w_wr_sel   = {r_wr_ptr, ~r_wr_ptr};
  assign w_rd_sel   = {r_rd_ptr, ~r_rd_ptr};
  assign w_wr_state = r_wr_ptr ? w_state[1] : w_state[0];
  assign w_rd_state = r_rd_ptr ? w_state[1] : w_state[0];
  assign w_rd_data  = r_rd_ptr ? w_bank_data[1] : w_bank_data[0];

  // r_run keeps in_ready low during reset and releases it one edge later.
  assign in_ready  = r_run && ((r_fill_st == FSM_DRAIN) || (w_wr_state != BANK_FULL));
  assign out_valid = (w_rd_state == BANK_FULL);
  assign data      = out_valid ? w_rd_data : '0;
  assign frame_error = r_frame_error;

  assign w_accept    = in_valid && in_ready;
  assign w_fill_beat = w_accept && (r_fill_st == FSM_FILL);
  assign w_at_last   = (r_idx == LAST_IDX);
  assign w_complete  = w_fill_beat && in_last && w_at_last;
  assign w_missing   = w_fill_beat && !in_last && w_at_last;
  assign w_bad_frame = (w_fill_beat && in_last && !w_at_last) || w_missing;
  assign w_release   = frame_release && out_valid;

  // Release always hits the FULL read bank and a fill beat hits the non-FULL
  // write bank, so the two updates never land on the same bank.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_state_d[b] = w_state[b];
      if (w_release && w_rd_sel[b]) w_state_d[b] = BANK_EMPTY;
      if (w_fill_beat && w_wr_sel[b]) begin
        if (w_complete)       w_state_d[b] = BANK_FULL;
        else if (w_bad_frame) w_state_d[b] = BANK_EMPTY;
        else                  w_state_d[b] = BANK_FILLING;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    mlp_frame_bank #(
      .n                      (n),
      .number_of_inputs       (number_of_inputs),
      .clog2_number_of_inputs (clog2_number_of_inputs)
    ) u_bank (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_fill_beat && w_wr_sel[g]),
      .i_idx     (r_idx),
      .i_pixel   (in_data),
      .i_state_d (w_state_d[g]),
      .o_state   (w_state[g]),
      .o_data    (w_bank_data[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run         <= 1'b0;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_idx         <= '0;
      r_fill_st     <= FSM_FILL;
      r_frame_error <= 1'b0;
    end else begin
      r_run         <= 1'b1;
      r_frame_error <= w_bad_frame;
      if (w_complete) r_wr_ptr <= ~r_wr_ptr;
      if (w_release)  r_rd_ptr <= ~r_rd_ptr;
      if (w_fill_beat) begin
        if (in_last || w_at_last) r_idx <= '0;
        else                      r_idx <= r_idx + 1'b1;
      end
      case (r_fill_st)
        FSM_FILL:  if (w_missing) r_fill_st <= FSM_DRAIN;
        FSM_DRAIN: if (w_accept && in_last) r_fill_st <= FSM_FILL;
        default:   r_fill_st <= FSM_FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_mlp_input_buffer.sv
// Randomized bench for mlp_input_buffer against a queue-based frame model,
// plus hand-computed literal checks for the directed scenarios.
module tb_mlp_input_buffer;
  localparam int N  = 8;
  localparam int NI = 62;
  localparam int DW = N * NI;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [N-1:0]  in_data = '0;
  logic          in_last = 1'b0;
  logic          frame_release = 1'b0;
  logic          in_ready, out_valid, frame_error;
  logic [DW-1:0] data;

  int n_chk = 0;
  int n_err = 0;
  bit done = 0;
  int gap_pct = 0;
  bit a_done = 0;

  mlp_input_buffer #(.n(N), .number_of_inputs(NI), .clog2_number_of_inputs(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .data(data),
    .frame_release(frame_release), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  // Behavioural model: queue of presented/held frames, partial frame, drain flag.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_cur;
  int  m_cnt = 0;
  bit  m_drain = 0;
  bit  m_run = 0;
  bit  m_err = 0;
  bit  m_rdy, m_acc, m_rel;

  function automatic bit model_ready();
    return m_run && (m_drain || q.size() < 2);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete(); m_cnt = 0; m_drain = 0; m_run = 0; m_err = 0;
    end else begin
      m_rdy = model_ready();
      m_acc = in_valid && m_rdy;
      m_rel = frame_release && (q.size() > 0);
      m_err = 0;
      if (m_rel) q.delete(0);
      if (m_acc) begin
        if (m_drain) begin
          if (in_last) m_drain = 0;
        end else begin
          m_cur[m_cnt*N +: N] = in_data;
          m_cnt++;
          if (in_last) begin
            if (m_cnt == NI) q.push_back(m_cur);
            else m_err = 1;
            m_cnt = 0;
          end else if (m_cnt == NI) begin
            m_err = 1; m_drain = 1; m_cnt = 0;
          end
        end
      end
      m_run = 1;
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!done) begin
      chk("in_ready", DW'(in_ready), DW'(model_ready()));
      chk("out_valid", DW'(out_valid), DW'(q.size() > 0));
      chk("data", data, (q.size() > 0) ? q[0] : '0);
      chk("frame_error", DW'(frame_error), DW'(m_err));
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic beat(input logic [7:0] d, input bit last, input bit rel);
    bit ok;
    ok = 0;
    in_valid = 1; in_data = d; in_last = last;
    if (rel) frame_release = 1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk); ok = in_ready;
      step();
      if (rel) frame_release = 0;
    end
    in_valid = 0; in_last = 0;
    if (!ok) chk("beat_timeout", DW'(ok), DW'(1));
  endtask

  // mode 0: constant val, 1: ramp k+1, 2: random pixels
  task automatic send_frame(input int mode, input logic [7:0] val, input int nb,
                            input int last_at, input bit rel_last);
    logic [7:0] px;
    for (int k = 0; k < nb; k++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) step();
      px = (mode == 0) ? val : (mode == 1) ? 8'(k + 1) : 8'($urandom);
      beat(px, k == last_at, rel_last && (k == nb - 1));
    end
  endtask

  task automatic rel_pulse();
    frame_release = 1; step(); frame_release = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    step(); step();
    @(negedge clk);
    chk("rst_in_ready", DW'(in_ready), DW'(0));
    chk("rst_data", data, '0);
    step(); rst = 0; step();
    @(negedge clk);
    chk("post_rst_in_ready", DW'(in_ready), DW'(1));
    step();

    // Single ramp frame
    send_frame(1, 8'h00, NI, NI - 1, 0);
    @(negedge clk);
    chk("single_out_valid", DW'(out_valid), DW'(1));
    chk("single_px0", DW'(data[7:0]), DW'(8'h01));
    chk("single_px61", DW'(data[495:488]), DW'(8'h3E));
    step();

    // Frame B fills while A is held
    send_frame(0, 8'hA0, NI, NI - 1, 0);
    @(negedge clk);
    chk("both_full_in_ready", DW'(in_ready), DW'(0));
    chk("both_full_px0", DW'(data[7:0]), DW'(8'h01));
    step();
    rel_pulse();
    @(negedge clk);
    chk("after_rel_px0", DW'(data[7:0]), DW'(8'hA0));
    chk("after_rel_in_ready", DW'(in_ready), DW'(1));
    step();
    rel_pulse();

    // Early last on beat 9
    send_frame(0, 8'h77, 10, 9, 0);
    @(negedge clk);
    chk("early_err", DW'(frame_error), DW'(1));
    chk("early_out_valid", DW'(out_valid), DW'(0));
    step();
    send_frame(0, 8'h55, NI, NI - 1, 0);
    @(negedge clk);
    chk("after_early_px0", DW'(data[7:0]), DW'(8'h55));
    step();
    rel_pulse();

    // Missing last, then drain three beats
    send_frame(2, 8'h00, NI, -1, 0);
    send_frame(2, 8'h00, 3, 2, 0);
    send_frame(0, 8'h5A, NI, NI - 1, 0);
    @(negedge clk);
    chk("after_drain_valid", DW'(out_valid), DW'(1));
    chk("after_drain_px61", DW'(data[495:488]), DW'(8'h5A));
    step();
    rel_pulse();

    // Release on the same edge that B completes
    send_frame(0, 8'h11, NI, NI - 1, 0);
    send_frame(0, 8'h22, NI, NI - 1, 1);
    @(negedge clk);
    chk("same_edge_px0", DW'(data[7:0]), DW'(8'h22));
    chk("same_edge_valid", DW'(out_valid), DW'(1));
    step();
    rel_pulse();

    // Reset mid-frame with a frame presented
    send_frame(0, 8'h33, NI, NI - 1, 0);
    send_frame(0, 8'h44, 30, -1, 0);
    rst = 1; #1;
    chk("midrst_out_valid", DW'(out_valid), DW'(0));
    chk("midrst_data", data, '0);
    step(); rst = 0; step();
    send_frame(0, 8'h66, NI, NI - 1, 0);
    @(negedge clk);
    chk("fresh_px61", DW'(data[495:488]), DW'(8'h66));
    step();
    rel_pulse();

    // Randomized traffic with random releases and stalls
    gap_pct = 25;
    fork
      begin
        for (int f = 0; f < 14; f++) begin
          kind = $urandom_range(5);
          if (kind == 0) send_frame(2, 8'h00, NI, -1, 0) ;
          if (kind == 0) send_frame(2, 8'h00, 4, 3, 0);
          else if (kind == 1) begin
            int la;
            la = $urandom_range(NI - 2);
            send_frame(2, 8'h00, la + 1, la, 0);
          end else send_frame(2, 8'h00, NI, NI - 1, 0);
        end
        a_done = 1;
      end
      begin
        for (int c = 0; c < 20000 && !a_done; c++) begin
          frame_release = ($urandom_range(3) == 0);
          step();
        end
        frame_release = 0;
      end
    join
    gap_pct = 0;
    repeat (3) begin step(); rel_pulse(); end
    step();
    done = 1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
